// File: rtl/conv_pkg.sv
// Shared types for the row convolution controller: pixel/coefficient types and FSM states.
package conv_pkg;

    typedef logic signed [7:0] pixel_t;
    typedef logic signed [7:0] coef_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoadK,
        StFill,
        StAccept,
        StMac,
        StOut,
        StDone
    } ctrl_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single 8-bit wrapping multiply-accumulate; clear has priority over enable.
module conv_mac
    import conv_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_clr,
    input  logic   i_en,
    input  pixel_t i_pix,
    input  coef_t  i_coef,
    output pixel_t o_acc
);

    pixel_t r_acc;
    pixel_t w_prod;

    // Only the low 8 bits of the product survive, giving modulo-256 arithmetic.
    assign w_prod = i_pix * i_coef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_row_ctrl.sv
// Row convolution controller: loads K taps, slides a K-pixel window along a D-pixel row and
// emits D-K+1 valid-region results through a single time-shared MAC.
module conv_row_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned D = 640,
    parameter int unsigned K = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_start,
    input  logic   i_kern_valid,
    output logic   o_kern_ready,
    input  coef_t  i_kern_data,
    input  logic   i_pix_valid,
    output logic   o_pix_ready,
    input  pixel_t i_pix_data,
    output logic   o_res_valid,
    input  logic   i_res_ready,
    output pixel_t o_res_data,
    output logic   o_busy,
    output logic   o_done
);

    localparam int unsigned NRes     = D - K + 1;
    localparam int unsigned TW       = cnt_w(K);
    localparam int unsigned OW       = cnt_w(NRes);
    localparam int unsigned FillLast = (K > 1) ? K - 2 : 0;

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;
    logic [TW-1:0] r_tap;
    logic [OW-1:0] r_ocnt;
    pixel_t        r_win  [K];
    coef_t         r_kern [K];

    logic   w_last_tap;
    logic   w_last_res;
    logic   w_pix_xfer;
    logic   w_start_job;
    logic   w_mac_clr;
    logic   w_mac_en;
    pixel_t w_tap_pix;
    coef_t  w_tap_coef;

    assign w_last_tap  = (r_tap == TW'(K - 1));
    assign w_last_res  = (r_ocnt == OW'(NRes - 1));
    assign w_pix_xfer  = o_pix_ready & i_pix_valid;
    assign w_start_job = (r_state == StIdle) & i_start;
    assign w_mac_clr   = w_start_job | ((r_state == StAccept) & i_pix_valid);
    assign w_mac_en    = (r_state == StMac);
    assign o_busy      = (r_state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_kern_ready = 1'b0;
        o_pix_ready  = 1'b0;
        o_res_valid  = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_nxt = StLoadK;
            end
            StLoadK: begin
                o_kern_ready = 1'b1;
                if (i_kern_valid && w_last_tap) w_state_nxt = (K > 1) ? StFill : StAccept;
            end
            StFill: begin
                o_pix_ready = 1'b1;
                if (i_pix_valid && (r_tap == TW'(FillLast))) w_state_nxt = StAccept;
            end
            StAccept: begin
                o_pix_ready = 1'b1;
                if (i_pix_valid) w_state_nxt = StMac;
            end
            StMac: begin
                if (w_last_tap) w_state_nxt = StOut;
            end
            StOut: begin
                o_res_valid = 1'b1;
                if (i_res_ready) w_state_nxt = w_last_res ? StDone : StAccept;
            end
            StDone: begin
                o_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap  <= '0;
            r_ocnt <= '0;
            for (int i = 0; i < int'(K); i++) begin
                r_win[i]  <= '0;
                r_kern[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_tap  <= '0;
                        r_ocnt <= '0;
                        for (int i = 0; i < int'(K); i++) r_win[i] <= '0;
                    end
                end
                StLoadK: begin
                    if (i_kern_valid) begin
                        for (int j = 0; j < int'(K); j++) begin
                            if (r_tap == TW'(j)) r_kern[j] <= i_kern_data;
                        end
                        r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
                    end
                end
                StFill: begin
                    if (i_pix_valid) r_tap <= (r_tap == TW'(FillLast)) ? '0 : r_tap + 1'b1;
                end
                StMac: r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
                StOut: begin
                    if (i_res_ready && !w_last_res) r_ocnt <= r_ocnt + 1'b1;
                end
                default: ;
            endcase
            // Newest pixel enters at the top so r_win[j] always pairs with r_kern[j].
            if (w_pix_xfer) begin
                for (int i = 0; i < int'(K) - 1; i++) r_win[i] <= r_win[i+1];
                r_win[K-1] <= i_pix_data;
            end
        end
    end

    always_comb begin
        w_tap_pix  = '0;
        w_tap_coef = '0;
        for (int j = 0; j < int'(K); j++) begin
            if (r_tap == TW'(j)) begin
                w_tap_pix  = r_win[j];
                w_tap_coef = r_kern[j];
            end
        end
    end

    conv_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_pix  (w_tap_pix),
        .i_coef (w_tap_coef),
        .o_acc  (o_res_data)
    );

endmodule

// File: tb/tb_conv_row_ctrl.sv
// Scoreboard bench for conv_row_ctrl: three instances (K=3/D=8, K=1/D=4, K=5/D=6) run in turn.
module tb_conv_row_ctrl;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic [2:0]      start      = '0;
    logic [2:0]      kern_valid = '0;
    logic [2:0]      pix_valid  = '0;
    logic [2:0]      res_ready  = 3'b111;
    logic [2:0][7:0] kern_data  = '0;
    logic [2:0][7:0] pix_data   = '0;
    logic [2:0]      kern_ready, pix_ready, res_valid, busy, done;
    logic [2:0][7:0] res_data;

    typedef struct {
        int         u;
        logic [7:0] v;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         t_acc[3], res_cnt[3], stall_idx[3], stall_left[3], done_cnt[3], exp_done[3];
    bit         prev_v[3];
    logic [7:0] kv[5], pv[8], ev[8];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GK = (g == 0) ? 3 : (g == 1) ? 1 : 5;
        localparam int unsigned GD = (g == 0) ? 8 : (g == 1) ? 4 : 6;
        conv_row_ctrl #(.D(GD), .K(GK)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_start      (start[g]),
            .i_kern_valid (kern_valid[g]),
            .o_kern_ready (kern_ready[g]),
            .i_kern_data  (kern_data[g]),
            .i_pix_valid  (pix_valid[g]),
            .o_pix_ready  (pix_ready[g]),
            .i_pix_data   (pix_data[g]),
            .o_res_valid  (res_valid[g]),
            .i_res_ready  (res_ready[g]),
            .o_res_data   (res_data[g]),
            .o_busy       (busy[g]),
            .o_done       (done[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int kk(input int u);
        return (u == 0) ? 3 : (u == 1) ? 1 : 5;
    endfunction

    function automatic int dd(input int u);
        return (u == 0) ? 8 : (u == 1) ? 4 : 6;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer, applies planned backpressure.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (!rst_n) begin
                prev_v[u]    = 1'b0;
                res_ready[u] = 1'b1;
            end else begin
                if (res_valid[u] && !prev_v[u]) chk("latency", cyc, t_acc[u] + kk(u) + 1);
                prev_v[u] = res_valid[u];
                if (res_valid[u] && res_cnt[u] == stall_idx[u] && stall_left[u] > 0) begin
                    res_ready[u] = 1'b0;
                    stall_left[u]--;
                    chk("stall_pix_ready", int'(pix_ready[u]), 0);
                    if (q.size() > 0) chk("stall_hold", int'(res_data[u]), int'(q[0].v));
                end else begin
                    res_ready[u] = 1'b1;
                end
                if (res_valid[u] && res_ready[u]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: dut%0d gave 0x%0h, none expected",
                                 u, res_data[u]);
                    end else begin
                        mon_e = q.pop_front();
                        chk("result_dut", u, mon_e.u);
                        chk("result", int'(res_data[u]), int'(mon_e.v));
                        res_cnt[u]++;
                    end
                end
                if (done[u]) begin
                    done_cnt[u]++;
                    chk("done_after_last", q.size(), 0);
                end
            end
        end
    end

    task automatic send(input int u, input bit is_kern, input logic [7:0] v, input bit acc);
        int n    = 0;
        bit sent = 1'b0;
        if (is_kern) begin
            kern_valid[u] = 1'b1;
            kern_data[u]  = v;
        end else begin
            pix_valid[u] = 1'b1;
            pix_data[u]  = v;
        end
        while (!sent && n < 100) begin
            if (is_kern ? kern_ready[u] : pix_ready[u]) begin
                chk("ready_exclusive", int'(kern_ready[u] & pix_ready[u]), 0);
                if (acc) t_acc[u] = cyc;
                @(posedge clk);
                @(negedge clk);
                sent = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!sent) chk("handshake_timeout", 0, 1);
        kern_valid[u] = 1'b0;
        pix_valid[u]  = 1'b0;
    endtask

    task automatic run_row(input int u, input bit hold, input int abort_at);
        int   n = 0;
        exp_t e;
        res_cnt[u] = 0;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        if (!hold) start[u] = 1'b0;
        for (int j = 0; j < kk(u); j++) send(u, 1'b1, kv[j], 1'b0);
        for (int i = 0; i < dd(u); i++) begin
            if (i >= kk(u) - 1) begin
                e.u = u;
                e.v = ev[i-kk(u)+1];
                q.push_back(e);
            end
            send(u, 1'b0, pv[i], i >= kk(u) - 1);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", int'(busy[u]), 0);
                chk("abort_res_valid", int'(res_valid[u]), 0);
                chk("abort_pix_ready", int'(pix_ready[u]), 0);
                chk("abort_res_data", int'(res_data[u]), 0);
                q.delete();
                repeat (2) @(negedge clk);
                rst_n    = 1'b1;
                start[u] = 1'b0;
                return;
            end
        end
        while (!done[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(n < 200), 1);
        exp_done[u]++;
        start[u] = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt[u], exp_done[u]);
        chk("idle_after_done", int'(busy[u]), 0);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic set_row121();
        kv[0] = 8'd1;
        kv[1] = 8'd2;
        kv[2] = 8'd1;
        for (int i = 0; i < 8; i++) pv[i] = 8'(i + 1);
        for (int i = 0; i < 6; i++) ev[i] = 8'(8 + 4 * i);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("reset_outputs", int'({busy[u], kern_ready[u], pix_ready[u], res_valid[u],
                                       done[u], res_data[u]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        set_row121();
        run_row(0, 1'b0, -1);

        for (int j = 0; j < 3; j++) kv[j] = 8'd127;
        for (int i = 0; i < 8; i++) pv[i] = 8'd2;
        for (int i = 0; i < 6; i++) ev[i] = 8'hFA;
        run_row(0, 1'b0, -1);

        set_row121();
        stall_idx[0]  = 1;
        stall_left[0] = 10;
        run_row(0, 1'b0, -1);
        chk("stall_consumed", stall_left[0], 0);

        stall_idx[0] = -1;
        run_row(0, 1'b0, 4);
        chk("abort_no_done", done_cnt[0], exp_done[0]);
        run_row(0, 1'b0, -1);

        run_row(0, 1'b1, -1);

        kv[0] = 8'd3;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 8'(i + 1);
            ev[i] = 8'(3 * (i + 1));
        end
        stall_idx[1] = -1;
        run_row(1, 1'b1, -1);

        kv[0] = 8'd1;
        kv[1] = 8'hFF;
        kv[2] = 8'd2;
        kv[3] = 8'd0;
        kv[4] = 8'd1;
        for (int i = 0; i < 6; i++) pv[i] = 8'(i + 1);
        ev[0] = 8'd10;
        ev[1] = 8'd13;
        stall_idx[2] = -1;
        run_row(2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1);
    end

endmodule
